unidade_controle: RTL and testbench
===================================

# unidade_controle

Multicycle control FSM for the 64-bit RISC-V CPU: sequences fetch/decode/execute/memory/writeback for each instruction in the instruction register and drives every datapath select and write-enable. Sits directly upstream of the datapath (PC, IR, register bank, ULA, 32/64-bit memories); it consumes `opcode` and the ULA zero flag and exports the phase code `STT` that the CPU brings out to the top-level monitor.

## Interface
- `MEM_WAIT`, default 1: extra wait cycles per memory access (0..7); every memory state lasts `MEM_WAIT+1` cycles.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  32  current IR contents (full instruction word).
- `zero`  in  1  ULA zero flag, combinational, same cycle.
- `pc_write`  out  1  load PC.
- `pc_src`  out  1  PC input: 0 = ULA result, 1 = ALUOut register.
- `ir_write`  out  1  load IR and latch old_pc.
- `mem32_rd`  out  1  instruction memory read.
- `mem64_rd` / `mem64_wr`  out  1 each  data memory read/write.
- `mdr_write`  out  1  load MDR.
- `reg_write`  out  1  register bank write to rd.
- `wb_sel`  out  2  writeback source: 0 ALUOut, 1 MDR, 2 PC.
- `alu_src_a`  out  2  0 PC, 1 reg A, 2 old_pc, 3 zero.
- `alu_src_b`  out  2  0 reg B, 1 constant 4, 2 immediate.
- `alu_op`  out  3  ULA function (package constants).
- `aluout_write`  out  1  load ALUOut.
- `halted`  out  1  FSM is in HALT.
- `STT`  out  3  phase: 0 reset, 1 fetch, 2 decode, 3 execute, 4 memory, 5 writeback, 7 halt.

## Operation
- Supported: add/sub (0110011, f3 000, f7 0000000/0100000), addi (0010011 f3 000), ld (0000011 f3 011), sd (0100011 f3 011), beq/bne (1100011 f3 000/001), lui (0110111), jal (1101111). Anything else, including bad funct3/funct7, -> HALT.
- States: RST -> FETCH -> DECODE -> {EXEC_R, EXEC_I, ADDR, BRANCH, LUI, JAL, HALT}.
- FETCH: `mem32_rd`=1; A=PC, B=4, ADD. In its final cycle, `ir_write`=`pc_write`=1, `pc_src`=0.
- DECODE: A=old_pc, B=imm, ADD, `aluout_write`=1 (branch/jump target).
- EXEC_R: A=reg A, B=reg B, ADD or SUB, `aluout_write` -> WB_ALU.
- EXEC_I: A=reg A, B=imm, ADD, `aluout_write` -> WB_ALU.
- LUI: A=zero, B=imm, ADD, `aluout_write` -> WB_ALU.
- ADDR: A=reg A, B=imm, ADD, `aluout_write` -> MEM_RD (ld) or MEM_WR (sd).
- MEM_RD: `mem64_rd`; final cycle `mdr_write` -> WB_MEM.
- MEM_WR: `mem64_wr` held all cycles -> FETCH.
- WB_ALU: `reg_write`, `wb_sel`=0 -> FETCH. WB_MEM: `reg_write`, `wb_sel`=1 -> FETCH.
- BRANCH: A=reg A, B=reg B, SUB; `pc_src`=1; `pc_write` = beq&zero | bne&~zero -> FETCH.
- JAL: `reg_write`, `wb_sel`=2 (PC already = old_pc+4), `pc_write`, `pc_src`=1 -> FETCH.
- HALT: all enables 0, `halted`=1; held until reset.
- Wait counter: 3-bit, cleared on entering any memory state, advances each cycle; the state exits when it equals `MEM_WAIT`.

## Timing
- Moore outputs, decoded from state and the wait counter only; `zero` is the sole combinational input path (BRANCH `pc_write`).
- `reset` low: state=RST, counter=0, all enables 0, selects 0, `STT`=0, `halted`=0, immediately and asynchronously. First rising edge with `reset` high -> FETCH.
- Cycle counts with `MEM_WAIT`=W: R/I/lui = W+4; ld = 2W+6; sd = 2W+5; beq/bne = W+3; jal = W+3.
- `reset` asserted mid-instruction (including inside a memory wait): abort at once, no further write enable asserted; restart at FETCH.
- Counter compare is exact; W=0 means single-cycle memory states.

## Structure
- Package `cpu_ctrl_pkg`: state enum, `STT` phase constants, opcode/funct constants, `alu_op` codes (ADD=3'b001, SUB=3'b010), `wb_sel` and `alu_src_*` encodings. Shared with the datapath and ULA.
- One sub-module `instr_class_dec`: combinational opcode/funct3/funct7 -> instruction class and illegal flag. FSM, counter and output decode live in `unidade_controle`.

## Test plan
- Reset held 3 cycles then released, W=1 -> all outputs 0 and `STT`=0 during reset; next edge `STT`=1, `mem32_rd`=1; `ir_write`/`pc_write` high exactly in 2nd FETCH cycle.
- add x3,x1,x2 (0x002081B3), W=1 -> STT 1,1,2,3,5; `alu_op`=ADD in EXEC; `reg_write`, `wb_sel`=0 in cycle 5 only.
- ld x5,8(x1) (0x0080B283), W=2 -> 10 cycles; `mem64_rd` 3 cycles; `mdr_write` in the last of them; then `wb_sel`=1.
- beq with `zero`=1 -> `pc_write`=1, `pc_src`=1 in BRANCH; repeat with `zero`=0 -> `pc_write`=0; bne inverted.
- opcode 0xFFFFFFFF -> DECODE then HALT; `STT`=7, `halted`=1, no enables for 20 cycles; reset -> FETCH.
- sd with W=3, `reset` low in 2nd MEM_WR cycle -> `mem64_wr` drops in the same time step; after release, FETCH.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit, datapath and ULA:
//   - state_t      : control FSM states
//   - instr_cls_t  : decoded instruction class
//   - STT_*        : phase codes exported to the top-level monitor
//   - OPC_/F3_/F7_ : opcode, funct3 and funct7 field values
//   - ALU_*        : ULA function codes
//   - WB_*, SRC_A_*, SRC_B_* : datapath mux encodings
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_BRANCH = 4'd6,
    S_LUI    = 4'd7,
    S_JAL    = 4'd8,
    S_MEM_RD = 4'd9,
    S_MEM_WR = 4'd10,
    S_WB_ALU = 4'd11,
    S_WB_MEM = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADD     = 4'd0,
    CLS_SUB     = 4'd1,
    CLS_ADDI    = 4'd2,
    CLS_LD      = 4'd3,
    CLS_SD      = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_cls_t;

  // Phase codes seen on STT
  localparam logic [2:0] STT_RESET     = 3'd0;
  localparam logic [2:0] STT_FETCH     = 3'd1;
  localparam logic [2:0] STT_DECODE    = 3'd2;
  localparam logic [2:0] STT_EXECUTE   = 3'd3;
  localparam logic [2:0] STT_MEMORY    = 3'd4;
  localparam logic [2:0] STT_WRITEBACK = 3'd5;
  localparam logic [2:0] STT_HALT      = 3'd7;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // ULA function codes
  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Writeback source
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // ULA operand selects
  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;
  localparam logic [1:0] SRC_B_REG   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;

  // Map an FSM state onto its externally visible phase code
  function automatic logic [2:0] stt_of(state_t s);
    logic [2:0] r;
    case (s)
      S_RST:                                    r = STT_RESET;
      S_FETCH:                                  r = STT_FETCH;
      S_DECODE:                                 r = STT_DECODE;
      S_EXEC_R, S_EXEC_I, S_ADDR, S_BRANCH,
      S_LUI, S_JAL:                             r = STT_EXECUTE;
      S_MEM_RD, S_MEM_WR:                       r = STT_MEMORY;
      S_WB_ALU, S_WB_MEM:                       r = STT_WRITEBACK;
      S_HALT:                                   r = STT_HALT;
      default:                                  r = STT_RESET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// -----------------------------------------------------------------------------
// unidade_controle_if
// Control bus between the control FSM and the datapath.
//   master : control unit side (consumes opcode/zero, drives all controls)
//   slave  : datapath side
// -----------------------------------------------------------------------------
interface unidade_controle_if;
  import cpu_ctrl_pkg::*;

  logic [31:0] opcode;
  logic        zero;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        mem32_rd;
  logic        mem64_rd;
  logic        mem64_wr;
  logic        mdr_write;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        aluout_write;
  logic        halted;
  logic [2:0]  STT;

  modport master (
    input  opcode, zero,
    output pc_write, pc_src, ir_write, mem32_rd, mem64_rd, mem64_wr,
           mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           aluout_write, halted, STT
  );

  modport slave (
    output opcode, zero,
    input  pc_write, pc_src, ir_write, mem32_rd, mem64_rd, mem64_wr,
           mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
           aluout_write, halted, STT
  );

endinterface

// File: rtl/unidade_controle_instr_class_dec.sv
// -----------------------------------------------------------------------------
// instr_class_dec
// Combinational instruction classifier.
//   opc_i     : instruction bits [6:0]
//   funct3_i  : instruction bits [14:12]
//   funct7_i  : instruction bits [31:25]
//   cls_o     : instruction class
//   illegal_o : encoding not supported by this core
// -----------------------------------------------------------------------------
module instr_class_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opc_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output instr_cls_t cls_o,
  output logic       illegal_o
);

  // Classify the instruction; any unlisted field combination is illegal
  always_comb begin
    cls_o = CLS_ILLEGAL;
    case (opc_i)
      OPC_OP: begin
        if (funct3_i == F3_ADD_SUB && funct7_i == F7_ADD) begin
          cls_o = CLS_ADD;
        end else if (funct3_i == F3_ADD_SUB && funct7_i == F7_SUB) begin
          cls_o = CLS_SUB;
        end else begin
          cls_o = CLS_ILLEGAL;
        end
      end
      OPC_OP_IMM: begin
        if (funct3_i == F3_ADD_SUB) cls_o = CLS_ADDI;
        else                        cls_o = CLS_ILLEGAL;
      end
      OPC_LOAD: begin
        if (funct3_i == F3_DWORD) cls_o = CLS_LD;
        else                      cls_o = CLS_ILLEGAL;
      end
      OPC_STORE: begin
        if (funct3_i == F3_DWORD) cls_o = CLS_SD;
        else                      cls_o = CLS_ILLEGAL;
      end
      OPC_BRANCH: begin
        if (funct3_i == F3_BEQ)      cls_o = CLS_BEQ;
        else if (funct3_i == F3_BNE) cls_o = CLS_BNE;
        else                         cls_o = CLS_ILLEGAL;
      end
      OPC_LUI: cls_o = CLS_LUI;
      OPC_JAL: cls_o = CLS_JAL;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
// Multicycle control FSM for the 64-bit RISC-V CPU.
//   MEM_WAIT : extra wait cycles per memory access (0..7)
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   bus      : control bus (master side) - opcode/zero in, all datapath
//              selects and write enables, halted and STT out
// Outputs are Moore-decoded from state, wait counter and the instruction
// class latched in DECODE; the only combinational input path is zero into
// pc_write during BRANCH.
// -----------------------------------------------------------------------------
module unidade_controle
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
)(
  input logic               clock,
  input logic               reset,
  unidade_controle_if.master bus
);

  localparam logic [2:0] WAIT_C = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  instr_cls_t cls_q, cls_d;

  instr_cls_t dec_cls_s;
  logic       dec_illegal_s;
  logic       wait_done_s;

  instr_class_dec u_dec (
    .opc_i     (bus.opcode[6:0]),
    .funct3_i  (bus.opcode[14:12]),
    .funct7_i  (bus.opcode[31:25]),
    .cls_o     (dec_cls_s),
    .illegal_o (dec_illegal_s)
  );

  assign wait_done_s = (cnt_q == WAIT_C);

  // State, wait counter and latched instruction class registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= 3'd0;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state logic; the counter only advances while a timed state is held,
  // so it is always zero on entry to the next timed state
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    cls_d   = cls_q;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        if (wait_done_s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls_s;
        if (dec_illegal_s) begin
          state_d = S_HALT;
        end else begin
          case (dec_cls_s)
            CLS_ADD, CLS_SUB: state_d = S_EXEC_R;
            CLS_ADDI:         state_d = S_EXEC_I;
            CLS_LD, CLS_SD:   state_d = S_ADDR;
            CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
            CLS_LUI:          state_d = S_LUI;
            CLS_JAL:          state_d = S_JAL;
            default:          state_d = S_HALT;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_WB_ALU;
      // Two cycles: the effective address sits in ALUOut for a whole cycle
      // before the data-memory strobe is raised
      S_ADDR: begin
        if (cnt_q == 3'd1) begin
          if (cls_q == CLS_LD) state_d = S_MEM_RD;
          else                 state_d = S_MEM_WR;
        end else begin
          state_d = S_ADDR;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_MEM_RD: begin
        if (wait_done_s) begin
          state_d = S_WB_MEM;
        end else begin
          state_d = S_MEM_RD;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_MEM_WR: begin
        if (wait_done_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_BRANCH, S_JAL, S_WB_ALU, S_WB_MEM: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Output decode
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_src       = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem32_rd     = 1'b0;
    bus.mem64_rd     = 1'b0;
    bus.mem64_wr     = 1'b0;
    bus.mdr_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = WB_ALUOUT;
    bus.alu_src_a    = SRC_A_PC;
    bus.alu_src_b    = SRC_B_REG;
    bus.alu_op       = ALU_NONE;
    bus.aluout_write = 1'b0;
    bus.halted       = 1'b0;
    bus.STT          = stt_of(state_q);
    case (state_q)
      S_RST: bus.halted = 1'b0;
      S_FETCH: begin
        bus.mem32_rd  = 1'b1;
        bus.alu_src_a = SRC_A_PC;
        bus.alu_src_b = SRC_B_FOUR;
        bus.alu_op    = ALU_ADD;
        if (wait_done_s) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end else begin
          bus.ir_write = 1'b0;
          bus.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        bus.alu_src_a    = SRC_A_OLDPC;
        bus.alu_src_b    = SRC_B_IMM;
        bus.alu_op       = ALU_ADD;
        bus.aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a    = SRC_A_REG;
        bus.alu_src_b    = SRC_B_REG;
        bus.aluout_write = 1'b1;
        if (cls_q == CLS_SUB) bus.alu_op = ALU_SUB;
        else                  bus.alu_op = ALU_ADD;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a    = SRC_A_REG;
        bus.alu_src_b    = SRC_B_IMM;
        bus.alu_op       = ALU_ADD;
        bus.aluout_write = 1'b1;
      end
      S_LUI: begin
        bus.alu_src_a    = SRC_A_ZERO;
        bus.alu_src_b    = SRC_B_IMM;
        bus.alu_op       = ALU_ADD;
        bus.aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        bus.mem64_rd = 1'b1;
        if (wait_done_s) bus.mdr_write = 1'b1;
        else             bus.mdr_write = 1'b0;
      end
      S_MEM_WR: bus.mem64_wr = 1'b1;
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_ALUOUT;
      end
      S_WB_MEM: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_MDR;
      end
      // ALUOut holds the target computed in DECODE; zero comes from A - B
      S_BRANCH: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_src_b = SRC_B_REG;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 1'b1;
        if (cls_q == CLS_BNE) bus.pc_write = ~bus.zero;
        else                  bus.pc_write = bus.zero;
      end
      // PC already holds old_pc + 4, which becomes the link value
      S_JAL: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_PC;
        bus.pc_write  = 1'b1;
        bus.pc_src    = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  typedef struct packed {
    logic       pc_write, pc_src, ir_write, mem32_rd, mem64_rd, mem64_wr, mdr_write, reg_write;
    logic [1:0] wb_sel, a, b;
    logic [2:0] op;
    logic       aluout, halted;
    logic [2:0] stt;
  } ov_t;

  localparam int C_ADD = 0, C_SUB = 1, C_ADDI = 2, C_LD = 3, C_SD = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_LUI = 7, C_JAL = 8, C_ILL = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] opcode = 32'h0;
  logic        zero = 1'b0;
  ov_t         act [4];
  int          p [4];
  int          cls_cur;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // One DUT per wait setting 0..3, all driven by the same stimulus
  for (genvar g = 0; g < 4; g++) begin : g_dut
    unidade_controle_if bus ();
    assign bus.opcode = opcode;
    assign bus.zero   = zero;
    unidade_controle #(.MEM_WAIT(g)) dut (.clock(clk), .reset(rst_n), .bus(bus));
    assign act[g] = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem32_rd, bus.mem64_rd,
                     bus.mem64_wr, bus.mdr_write, bus.reg_write, bus.wb_sel, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.aluout_write, bus.halted, bus.STT};
  end

  function automatic int classify(logic [31:0] x);
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] f7;
    o = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    if (o == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return C_ADD;
    if (o == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return C_SUB;
    if (o == 7'b0010011 && f3 == 3'b000) return C_ADDI;
    if (o == 7'b0000011 && f3 == 3'b011) return C_LD;
    if (o == 7'b0100011 && f3 == 3'b011) return C_SD;
    if (o == 7'b1100011 && f3 == 3'b000) return C_BEQ;
    if (o == 7'b1100011 && f3 == 3'b001) return C_BNE;
    if (o == 7'b0110111) return C_LUI;
    if (o == 7'b1101111) return C_JAL;
    return C_ILL;
  endfunction

  // Total cycles per instruction for wait setting w
  function automatic int instr_len(int w, int cls);
    case (cls)
      C_ADD, C_SUB, C_ADDI, C_LUI: return w + 4;
      C_LD:                        return 2 * w + 6;
      C_SD:                        return 2 * w + 5;
      C_BEQ, C_BNE, C_JAL:         return w + 3;
      default:                     return 1000000;
    endcase
  endfunction

  // Expected outputs at cycle p of an instruction (p < 0: in reset)
  function automatic ov_t model(int w, int cls, int p, logic z);
    ov_t e;
    int  q;
    e = '0;
    if (p < 0) return e;
    if (p <= w) begin
      e.stt = 3'd1; e.mem32_rd = 1'b1; e.a = 2'd0; e.b = 2'd1; e.op = 3'b001;
      if (p == w) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      return e;
    end
    if (p == w + 1) begin
      e.stt = 3'd2; e.a = 2'd2; e.b = 2'd2; e.op = 3'b001; e.aluout = 1'b1;
      return e;
    end
    q = p - (w + 2);
    if (cls == C_ILL) begin e.stt = 3'd7; e.halted = 1'b1; return e; end
    if (cls == C_BEQ || cls == C_BNE) begin
      e.stt = 3'd3; e.a = 2'd1; e.b = 2'd0; e.op = 3'b010; e.pc_src = 1'b1;
      e.pc_write = (cls == C_BEQ) ? z : ~z;
      return e;
    end
    if (cls == C_JAL) begin
      e.stt = 3'd3; e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_src = 1'b1;
      return e;
    end
    if (cls == C_LD || cls == C_SD) begin
      if (q <= 1) begin
        e.stt = 3'd3; e.a = 2'd1; e.b = 2'd2; e.op = 3'b001; e.aluout = 1'b1;
      end else if (q <= w + 2) begin
        e.stt = 3'd4;
        if (cls == C_LD) begin e.mem64_rd = 1'b1; e.mdr_write = (q == w + 2); end
        else e.mem64_wr = 1'b1;
      end else begin
        e.stt = 3'd5; e.reg_write = 1'b1; e.wb_sel = 2'd1;
      end
      return e;
    end
    // add / sub / addi / lui
    if (q == 0) begin
      e.stt = 3'd3; e.aluout = 1'b1;
      e.op = (cls == C_SUB) ? 3'b010 : 3'b001;
      e.a = (cls == C_LUI) ? 2'd3 : 2'd1;
      e.b = (cls == C_ADD || cls == C_SUB) ? 2'd0 : 2'd2;
    end else begin
      e.stt = 3'd5; e.reg_write = 1'b1; e.wb_sel = 2'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [19:0] u;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm = 12'($urandom); u = 20'($urandom);
    case ($urandom_range(0, 11))
      0:  return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      1:  return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      2:  return {imm, rs1, 3'b000, rd, 7'b0010011};
      3:  return {imm, rs1, 3'b011, rd, 7'b0000011};
      4:  return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      5:  return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
      6:  return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
      7:  return {u, rd, 7'b0110111};
      8:  return {u, rd, 7'b1101111};
      9:  return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
      10: return {imm[11:5], rs2, rs1, 3'b100, imm[4:0], 7'b1100011};
      default: return $urandom;
    endcase
  endfunction

  // Advance one clock edge and the reference position of every DUT
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!rst_n)                                 p[k] = -1;
      else if (p[k] < 0)                          p[k] = 0;
      else if (p[k] + 1 >= instr_len(k, cls_cur)) p[k] = 0;
      else                                        p[k] = p[k] + 1;
    end
    #1;
  endtask

  task automatic hold_reset(int n);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) p[k] = -1;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ov_t e;
    opcode = 32'h002081B3; cls_cur = classify(opcode);
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (act[k] !== ov_t'(0)) begin
          n_bad++; $display("FAIL reset W=%0d c=%0d: got %h want 0", k, c, act[k]);
        end
      end
      if (c < 3) tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        e = model(k, cls_cur, p[k], zero);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++; $display("FAIL reset_release W=%0d p=%0d: got %h want %h", k, p[k], act[k], e);
        end
      end
      n_cmp++;
      if (act[1].stt !== 3'd1 || act[1].mem32_rd !== 1'b1 || act[1].ir_write !== (c == 1)
          || act[1].pc_write !== (c == 1)) begin
        n_bad++; $display("FAIL fetch_w1 c=%0d: got %h", c, act[1]);
      end
    end
  endtask

  task automatic test_add();
    ov_t        e;
    logic [2:0] stt_exp [5];
    stt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd5};
    opcode = 32'h002081B3; cls_cur = classify(opcode);
    hold_reset(1);
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        e = model(k, cls_cur, p[k], zero);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++; $display("FAIL add W=%0d p=%0d: got %h want %h", k, p[k], act[k], e);
        end
      end
      if (c < 5) begin
        n_cmp++;
        if (act[1].stt !== stt_exp[c] || act[1].reg_write !== (c == 4)
            || (c == 3 && act[1].op !== 3'b001)) begin
          n_bad++; $display("FAIL add_seq c=%0d: got %h stt_want %0d", c, act[1], stt_exp[c]);
        end
      end
    end
  endtask

  task automatic test_ld();
    ov_t e;
    int  rd_cnt;
    rd_cnt = 0;
    opcode = 32'h0080B283; cls_cur = classify(opcode);
    hold_reset(1);
    for (int c = 0; c < 11; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        e = model(k, cls_cur, p[k], zero);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++; $display("FAIL ld W=%0d p=%0d: got %h want %h", k, p[k], act[k], e);
        end
      end
      if (c < 10 && act[2].mem64_rd === 1'b1) rd_cnt++;
      n_cmp++;
      if (act[2].mdr_write !== (c == 8) || (c == 9 && (act[2].wb_sel !== 2'd1 || act[2].reg_write !== 1'b1))
          || (c == 10 && act[2].stt !== 3'd1)) begin
        n_bad++; $display("FAIL ld_w2 c=%0d: got %h", c, act[2]);
      end
    end
    n_cmp++;
    if (rd_cnt !== 3) begin
      n_bad++; $display("FAIL ld_rd_cycles: got %0d want 3", rd_cnt);
    end
  endtask

  task automatic test_branch();
    ov_t         e;
    logic [31:0] ins [2];
    ins = '{32'h00208463, 32'h00209463};
    for (int i = 0; i < 2; i++) begin
      for (int zv = 1; zv >= 0; zv--) begin
        opcode = ins[i]; cls_cur = classify(opcode); zero = zv[0];
        hold_reset(1);
        for (int c = 0; c < 6; c++) begin
          tick();
          for (int k = 0; k < 4; k++) begin
            e = model(k, cls_cur, p[k], zero);
            n_cmp++;
            if (act[k] !== e) begin
              n_bad++; $display("FAIL branch%0d z=%0d W=%0d p=%0d: got %h want %h", i, zv, k, p[k], act[k], e);
            end
          end
          if (c == 3) begin
            n_cmp++;
            if (act[1].pc_write !== ((i == 0) ? zv[0] : ~zv[0]) || act[1].pc_src !== 1'b1) begin
              n_bad++; $display("FAIL branch_pcw%0d z=%0d: got %h", i, zv, act[1]);
            end
          end
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_halt();
    ov_t e;
    opcode = 32'hFFFFFFFF; cls_cur = classify(opcode);
    hold_reset(1);
    for (int c = 0; c < 26; c++) begin
      tick();
      zero = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        e = model(k, cls_cur, p[k], zero);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++; $display("FAIL halt W=%0d p=%0d: got %h want %h", k, p[k], act[k], e);
        end
        if (c >= 6) begin
          n_cmp++;
          if (act[k].halted !== 1'b1 || act[k].stt !== 3'd7) begin
            n_bad++; $display("FAIL halt_hold W=%0d c=%0d: got %h", k, c, act[k]);
          end
        end
      end
    end
    opcode = 32'h002081B3; cls_cur = classify(opcode);
    hold_reset(2);
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (act[k].stt !== 3'd1 || act[k].halted !== 1'b0) begin
        n_bad++; $display("FAIL halt_exit W=%0d: got %h", k, act[k]);
      end
    end
  endtask

  task automatic test_sd_reset();
    ov_t e;
    opcode = {7'b0, 5'd5, 5'd1, 3'b011, 5'b01000, 7'b0100011}; cls_cur = classify(opcode);
    hold_reset(1);
    for (int c = 0; c < 9; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        e = model(k, cls_cur, p[k], zero);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++; $display("FAIL sd W=%0d p=%0d: got %h want %h", k, p[k], act[k], e);
        end
      end
    end
    n_cmp++;
    if (act[3].mem64_wr !== 1'b1 || act[3].stt !== 3'd4) begin
      n_bad++; $display("FAIL sd_mid_w3: got %h want mem64_wr=1 stt=4", act[3]);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) p[k] = -1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (act[k] !== ov_t'(0)) begin
        n_bad++; $display("FAIL sd_abort W=%0d: got %h want 0", k, act[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      e = model(k, cls_cur, p[k], zero);
      n_cmp++;
      if (act[k] !== e || act[k].stt !== 3'd1) begin
        n_bad++; $display("FAIL sd_restart W=%0d: got %h want %h", k, act[k], e);
      end
    end
  endtask

  task automatic test_random();
    ov_t e;
    for (int i = 0; i < 30; i++) begin
      opcode = rand_insn(); cls_cur = classify(opcode);
      hold_reset(1);
      for (int c = 0; c < 20; c++) begin
        zero = 1'($urandom);
        tick();
        for (int k = 0; k < 4; k++) begin
          e = model(k, cls_cur, p[k], zero);
          n_cmp++;
          if (act[k] !== e) begin
            n_bad++; $display("FAIL random op=%h W=%0d p=%0d: got %h want %h", opcode, k, p[k], act[k], e);
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) p[k] = -1;
    #2 rst_n = 1'b0;
    test_reset();
    test_add();
    test_ld();
    test_branch();
    test_halt();
    test_sd_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
